gate_truth_checker: RTL and testbench

- Sequential exerciser for the two-input combinational gates in the basic-gates set (and/or/xor and similar).
- Drives the gate's a/b inputs through all four combinations and samples its y output.
- Compares each sample against a parameterised truth table and reports pass/fail per vector.
- Sits next to the gate under test in a bench or self-test wrapper.

---
 rtl/gate_truth_checker.sv | 148 ++++++++++++++
 tb/tb_gate_truth_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives a two-input gate through the vectors {a,b} =
// 00, 01, 10, 11, holds each for SETTLE_CYCLES+1 cycles, samples y on the
// last cycle and compares it with the EXPECT truth table.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          request a run (accepted only in IDLE; wins over abort)
//   abort          cancel a run in progress (APPLY only)
//   a, b           registered drive to the gate under test
//   y              gate output under test
//   busy           high while a run is in progress
//   done           one-cycle pulse on run completion (never on abort)
//   pass           last completed run had no mismatches
//   fail_mask      bit i set when vector i mismatched
//   err_count      number of mismatches, 0..4
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT        = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_APPLY  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [3:0]       fail_mask_nxt;
    logic [2:0]       err_count_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            fail_mask <= fail_mask_nxt;
            err_count <= err_count_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        a_nxt         = a;
        b_nxt         = b;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        pass_nxt      = pass;
        fail_mask_nxt = fail_mask;
        err_count_nxt = err_count;

        case (state)
            S_IDLE: begin
                a_nxt = 1'b0;
                b_nxt = 1'b0;
                if (start) begin
                    state_nxt     = S_APPLY;
                    idx_nxt       = '0;
                    cnt_nxt       = CNT_W'(SETTLE_CYCLES);
                    fail_mask_nxt = '0;
                    err_count_nxt = '0;
                    pass_nxt      = 1'b0;
                    busy_nxt      = 1'b1;
                end
            end

            S_APPLY: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    busy_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    // Written as equal/else so an unknown y lands on mismatch
                    if (y == EXPECT[idx]) begin
                        fail_mask_nxt = fail_mask;
                    end else begin
                        fail_mask_nxt[idx] = 1'b1;
                        err_count_nxt      = err_count + 3'd1;
                    end
                    if (idx != IDX_W'(3)) begin
                        idx_nxt        = idx + IDX_W'(1);
                        cnt_nxt        = CNT_W'(SETTLE_CYCLES);
                        {a_nxt, b_nxt} = idx + IDX_W'(1);
                    end else begin
                        state_nxt = S_FINISH;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        a_nxt     = 1'b0;
                        b_nxt     = 1'b0;
                        pass_nxt  = (err_count_nxt == 3'd0);
                    end
                end
            end

            S_FINISH: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                a_nxt     = 1'b0;
                b_nxt     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: a default instance exercised with
// AND / OR / stuck-at-0 gate models, plus a SETTLE_CYCLES=0 instance.
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic       a, b, y, busy, done, pass;
    logic [3:0] fail_mask;
    logic [2:0] err_count;

    logic       start0, abort0;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic [3:0] fail_mask0;
    logic [2:0] err_count0;

    int gate;  // 0 = AND, 1 = OR, other = stuck at 0
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (gate)
            0:       y = a & b;
            1:       y = a | b;
            default: y = 1'b0;
        endcase
    end

    assign y0     = a0 & b0;
    assign abort0 = 1'b0;

    gate_truth_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .err_count(err_count)
    );

    gate_truth_checker #(.SETTLE_CYCLES(0), .EXPECT(4'b1000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a(a0), .b(b0), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(fail_mask0), .err_count(err_count0)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run on u_dut with SETTLE_CYCLES=2; expected results given by caller
    task automatic run(input int g, input logic [3:0] em, input logic [2:0] ee,
                       input bit repulse, input bit with_abort);
        gate  = g;
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_busy", 8'(busy), 8'd1);
        chk("start_ab", 8'({a, b}), 8'd0);
        chk("start_clr_mask", 8'(fail_mask), 8'd0);
        chk("start_clr_err", 8'(err_count), 8'd0);
        chk("start_clr_pass", 8'(pass), 8'd0);
        for (int e = 1; e <= 12; e++) begin
            if (repulse && (e == 3 || e == 12)) start = 1'b1;
            tick();
            start = 1'b0;
            if (e < 12) begin
                chk("vec_ab", 8'({a, b}), 8'(e / 3));
                chk("done_low", 8'(done), 8'd0);
                chk("busy_high", 8'(busy), 8'd1);
            end
        end
        chk("fin_done", 8'(done), 8'd1);
        chk("fin_busy", 8'(busy), 8'd0);
        chk("fin_ab", 8'({a, b}), 8'd0);
        chk("fin_pass", 8'(pass), 8'(ee == 3'd0));
        chk("fin_mask", 8'(fail_mask), 8'(em));
        chk("fin_err", 8'(err_count), 8'(ee));
        if (repulse) start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_done", 8'(done), 8'd0);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("hold_pass", 8'(pass), 8'(ee == 3'd0));
        chk("hold_mask", 8'(fail_mask), 8'(em));
        chk("hold_err", 8'(err_count), 8'(ee));
        tick();
        chk("no_restart", 8'(busy), 8'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start0 = 1'b0;
        gate   = 0;
        #12;
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_pass", 8'(pass), 8'd0);
        chk("rst_mask", 8'(fail_mask), 8'd0);
        chk("rst_err", 8'(err_count), 8'd0);
        chk("rst_ab", 8'({a, b}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // AND gate, AND table: clean pass
        run(0, 4'b0000, 3'd0, 1'b0, 1'b0);
        // OR gate vs AND table: vectors 01 and 10 disagree, 11 agrees
        run(1, 4'b0110, 3'd2, 1'b1, 1'b0);
        // y stuck at 0: only vector 11 disagrees
        run(2, 4'b1000, 3'd1, 1'b0, 1'b0);
        // AND rerun with abort alongside start: start wins, results cleared
        run(0, 4'b0000, 3'd0, 1'b0, 1'b1);

        // Abort: vector 01 compared at edge 6 (OR mismatch), abort taken at edge 7
        gate  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_done", 8'(done), 8'd0);
        chk("abort_pass", 8'(pass), 8'd0);
        chk("abort_mask", 8'(fail_mask), 8'b0010);
        chk("abort_err", 8'(err_count), 8'd1);
        chk("abort_ab", 8'({a, b}), 8'd0);
        for (int e = 0; e < 8; e++) begin
            tick();
            chk("abort_no_done", 8'(done), 8'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 8'(busy), 8'd0);
        chk("idle_abort_mask", 8'(fail_mask), 8'b0010);
        chk("idle_abort_err", 8'(err_count), 8'd1);

        // Reset mid-run with OR gate so partial state is non-zero
        gate  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        chk("pre_rst_ab", 8'({a, b}), 8'b10);
        chk("pre_rst_mask", 8'(fail_mask), 8'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_done", 8'(done), 8'd0);
        chk("mid_rst_pass", 8'(pass), 8'd0);
        chk("mid_rst_mask", 8'(fail_mask), 8'd0);
        chk("mid_rst_err", 8'(err_count), 8'd0);
        chk("mid_rst_ab", 8'({a, b}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gate  = 0;
        tick();

        // SETTLE_CYCLES=0 instance with AND gate: done 4 edges after start
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("s0_busy", 8'(busy0), 8'd1);
        chk("s0_ab0", 8'({a0, b0}), 8'd0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("s0_vec_ab", 8'({a0, b0}), 8'(e));
            chk("s0_done_low", 8'(done0), 8'd0);
        end
        tick();
        chk("s0_done", 8'(done0), 8'd1);
        chk("s0_pass", 8'(pass0), 8'd1);
        chk("s0_mask", 8'(fail_mask0), 8'd0);
        chk("s0_err", 8'(err_count0), 8'd0);
        tick();
        chk("s0_done_clr", 8'(done0), 8'd0);
        chk("s0_busy_clr", 8'(busy0), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
